// File: rtl/lambda_update_pipe_pkg.sv
// Shared types and helpers for the lambda update pipeline.
// Default widths/fractions: mag Q6.10, rho Q1.7, phi Q6.10, lambda 16 bits.
package lambda_update_pipe_pkg;

  localparam int LANES_D = 4;
  localparam int MAG_W_D = 16;
  localparam int MAG_F_D = 10;
  localparam int RHO_W_D = 8;
  localparam int RHO_F_D = 7;
  localparam int PHI_W_D = 16;
  localparam int PHI_F_D = 10;
  localparam int OUT_W_D = 16;

  typedef logic signed [MAG_W_D-1:0] mag_t;
  typedef logic signed [RHO_W_D-1:0] rho_t;
  typedef logic signed [PHI_W_D-1:0] phi_t;
  typedef logic signed [OUT_W_D-1:0] lambda_t;

  // Clamp a wide signed value into the signed range of an out_w-bit result.
  function automatic logic signed [63:0] lambda_sat_fn(input logic signed [63:0] d,
                                                       input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (d > hi)      lambda_sat_fn = hi;
    else if (d < lo) lambda_sat_fn = lo;
    else             lambda_sat_fn = d;
  endfunction

endpackage

// File: rtl/lambda_update_pipe_lane.sv
// One lane of the second stage: floor-shift the product back to the mag
// fraction and subtract it from mag. Purely combinational.
// LAMBDA_SAT_EN selects the full-width clamped subtract; otherwise the
// subtract wraps exactly like the original single-lane update.
module lambda_lane
  import lambda_update_pipe_pkg::*;
#(
  parameter int MAG_W  = MAG_W_D,
  parameter int PROD_W = RHO_W_D + PHI_W_D,
  parameter int SH     = RHO_F_D + PHI_F_D - MAG_F_D,
  parameter int OUT_W  = OUT_W_D
) (
  input  logic signed [MAG_W-1:0]  mag,
  input  logic signed [PROD_W-1:0] prod,
  output logic        [OUT_W-1:0]  lambda,
  output logic                     sat
);

  localparam int P_W = PROD_W - SH;

  // Arithmetic shift gives floor rounding with no bias term.
  logic signed [PROD_W-1:0] prod_sh;
  assign prod_sh = prod >>> SH;

`ifdef LAMBDA_SAT_EN
  localparam int D_W = ((P_W > MAG_W) ? P_W : MAG_W) + 1;

  logic signed [P_W-1:0] p;
  logic signed [D_W-1:0] d;
  logic signed [63:0]    d_full;
  logic signed [63:0]    clamped;

  assign p       = P_W'(prod_sh);
  assign d       = D_W'(mag) - D_W'(p);
  assign d_full  = 64'(d);
  assign clamped = lambda_sat_fn(d_full, OUT_W);
  assign lambda  = OUT_W'(clamped);
  assign sat     = (clamped != d_full);
`else
  // Keep only the low MAG_W bits of p, then subtract modulo 2^OUT_W.
  logic signed [MAG_W-1:0] p_trunc;
  logic signed [OUT_W-1:0] mag_x;
  logic signed [OUT_W-1:0] p_x;

  assign p_trunc = MAG_W'(prod_sh);
  assign mag_x   = OUT_W'(mag);
  assign p_x     = OUT_W'(p_trunc);
  assign lambda  = mag_x - p_x;
  assign sat     = 1'b0;
`endif

endmodule

// File: rtl/lambda_update_pipe.sv
// Multi-lane two-stage elastic pipeline computing lambda = mag - rho*phi.
// Stage 1 registers the full-width products; stage 2 registers the shifted,
// subtracted (and optionally clamped) lambdas.
// Optional feature macro: LAMBDA_SAT_EN (saturating arithmetic, sat_cnt).
//
// Handshake: a beat moves across an interface on a clock edge where both
// valid and ready are high. Each stage holds one beat and loads when it is
// empty or its held beat leaves in the same cycle, so in_ready depends on
// out_ready combinationally and capacity is exactly two beats.
module lambda_update_pipe
  import lambda_update_pipe_pkg::*;
#(
  parameter int LANES = LANES_D,
  parameter int MAG_W = MAG_W_D,
  parameter int MAG_F = MAG_F_D,
  parameter int RHO_W = RHO_W_D,
  parameter int RHO_F = RHO_F_D,
  parameter int PHI_W = PHI_W_D,
  parameter int PHI_F = PHI_F_D,
  parameter int OUT_W = OUT_W_D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [LANES*MAG_W-1:0]   mag_in,
  input  logic [LANES*RHO_W-1:0]   rho_in,
  input  logic [LANES*PHI_W-1:0]   phi_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [LANES*OUT_W-1:0]   lambda_out,
  output logic [LANES-1:0]         sat_flag,
  output logic [15:0]              sat_cnt
);

  localparam int SH     = RHO_F + PHI_F - MAG_F;
  localparam int PROD_W = RHO_W + PHI_W;

  logic                      s1_valid;
  logic                      s1_last;
  logic [LANES*PROD_W-1:0]   s1_prod;
  logic [LANES*MAG_W-1:0]    s1_mag;
  logic [LANES*PROD_W-1:0]   prod_next;
  logic [LANES*OUT_W-1:0]    lambda_next;
  logic [LANES-1:0]          sat_next;
  logic                      s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign prod_next[i*PROD_W +: PROD_W] =
      PROD_W'($signed(rho_in[i*RHO_W +: RHO_W])) *
      PROD_W'($signed(phi_in[i*PHI_W +: PHI_W]));

    lambda_lane #(
      .MAG_W  (MAG_W),
      .PROD_W (PROD_W),
      .SH     (SH),
      .OUT_W  (OUT_W)
    ) u_lane (
      .mag    (s1_mag[i*MAG_W +: MAG_W]),
      .prod   (s1_prod[i*PROD_W +: PROD_W]),
      .lambda (lambda_next[i*OUT_W +: OUT_W]),
      .sat    (sat_next[i])
    );
  end

  // Stage 1: capture products, mag and frame marker when the stage can load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
      s1_mag   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last <= in_last;
        s1_prod <= prod_next;
        s1_mag  <= mag_in;
      end
    end
  end

  // Stage 2: output registers; data only changes when a new beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      lambda_out <= '0;
      sat_flag   <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_last   <= s1_last;
        lambda_out <= lambda_next;
        sat_flag   <= sat_next;
      end
    end
  end

`ifdef LAMBDA_SAT_EN
  logic [16:0] pop;
  logic [16:0] cnt_sum;

  // Count clamped lanes of the current output beat.
  always_comb begin
    pop = '0;
    for (int k = 0; k < LANES; k++) begin
      pop = pop + 17'(sat_flag[k]);
    end
    cnt_sum = {1'b0, sat_cnt} + pop;
  end

  // Accumulate clamp events on each output handshake, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      sat_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`else
  assign sat_cnt = '0;
`endif

endmodule
